// File: rtl/skid_pkg.sv
// Shared types for the 2-entry valid/ready skid buffer.
// State encoding and depth constant.
package skid_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    BUSY,
    FULL
  } skid_state_t;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/skid_buffer_props.sv
// Handshake contract for the skid buffer boundary.
// Pure observer: assumptions on the producer, assertions on the buffer.
module skid_buffer_props
  import skid_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] FORBIDDEN = '1
) (
  input logic             clk,
  input logic             rst_n,
  input logic             in_valid,
  input logic             in_ready,
  input logic [WIDTH-1:0] in_data,
  input logic             out_valid,
  input logic             out_ready,
  input logic [WIDTH-1:0] out_data,
  input logic             full,
  input skid_state_t      state
);

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  am_in_hold: assume property (
    @(posedge clk) disable iff (!rst_n)
    in_valid && !in_ready |=> in_valid && $stable(in_data));

  am_in_legal: assume property (
    @(posedge clk) disable iff (!rst_n)
    in_valid |-> in_data != FORBIDDEN);

  a_out_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
    out_valid && !out_ready |=> out_valid && $stable(out_data));

  a_out_legal: assert property (
    @(posedge clk) disable iff (!rst_n)
    out_valid |-> out_data != FORBIDDEN);

  a_full_excl: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(full && in_ready));

  a_full_state: assert property (
    @(posedge clk) disable iff (!rst_n)
    full == (state == FULL));

  // One-cycle lookback: full in the previous cycle, drained now.
  c_full_drain: cover property (
    @(posedge clk) disable iff (!rst_n)
    $past(full) && out_fire);

  c_in_out_fire: cover property (
    @(posedge clk) disable iff (!rst_n)
    in_fire && out_fire);

endmodule

// File: rtl/skid_buffer_checked.sv
// 2-entry skid buffer with registered ready, valid and data.
// Carries its own boundary property checker.
module skid_buffer_checked
  import skid_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] FORBIDDEN = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             full
);

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             full_q, full_d;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    skid_d      = skid_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    full_d      = full_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          out_data_d  = in_data;
          out_valid_d = 1'b1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          out_data_d = in_data;
        end else if (in_fire) begin
          skid_d     = in_data;
          in_ready_d = 1'b0;
          full_d     = 1'b1;
          state_d    = FULL;
        end else if (out_fire) begin
          out_valid_d = 1'b0;
          state_d     = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          out_data_d = skid_q;
          in_ready_d = 1'b1;
          full_d     = 1'b0;
          state_d    = BUSY;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        full_d      = 1'b0;
        state_d     = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_data_q  <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      full_q      <= full_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign full      = full_q;

  skid_buffer_props #(
    .WIDTH    (WIDTH),
    .FORBIDDEN(FORBIDDEN)
  ) u_props (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready_q),
    .in_data  (in_data),
    .out_valid(out_valid_q),
    .out_ready(out_ready),
    .out_data (out_data_q),
    .full     (full_q),
    .state    (state_q)
  );

endmodule
